ex_stage_mc: RTL
================

Name: ex_stage_mc

Overview:
Parametrised, registered execute stage for the MIPS integer pipeline. It sits between ID/EX and MEM.
- Single-cycle ops: logic, shift, add/sub, set-less-than; result registered in 1 cycle.
- Multi-cycle ops: iterative signed/unsigned divide writing HI/LO; `stall_req` holds upstream while it runs.
- Supports flush and an asynchronous active-low reset.

Parameters:
- DATA_W, 32, operand/result width (power of two, ≥8)
- ADDR_W, 5, register-file write address width
- SH_W, $clog2(DATA_W), shift-amount width (localparam, derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of the current op and any in-flight divide
- in_valid  in  1  instruction present on inputs this cycle
- alu_sel  in  3  result class: 001 logic, 010 shift, 100 arith, 101 divide
- alu_op  in  8  operation code (see Behaviour)
- src_data1  in  DATA_W  operand 1 / shift amount
- src_data2  in  DATA_W  operand 2 / shift value
- wr_addr  in  ADDR_W  destination register
- wr_en  in  1  destination write enable
- out_valid  out  1  registered result valid
- out_addr  out  ADDR_W  registered destination
- out_data  out  DATA_W  registered GPR result
- out_en  out  1  registered GPR write enable
- hi_out  out  DATA_W  divide remainder
- lo_out  out  DATA_W  divide quotient
- hi_lo_we  out  1  one-cycle HI/LO write strobe
- stall_req  out  1  combinational stall request to upstream

Behaviour:
Reset
- reset low, asynchronously: every output register goes to 0 and the divider goes to IDLE.
- stall_req = 0 while in reset.
- Reset during a divide discards it; no hi_lo_we is issued.

Opcodes (alu_op)
- OR 0x25, AND 0x24, XOR 0x26, NOR 0x27
- SLL 0x7C, SRL 0x02, SRA 0x03
- ADDU 0x21, SUBU 0x23, SLT 0x2A (signed), SLTU 0x2B
- DIV 0x1A, DIVU 0x1B

Single-cycle path
- in_valid=1, not a divide, flush=0: at the next edge register out_data=result, out_addr=wr_addr, out_en=wr_en, out_valid=1, hi_lo_we=0.
- Unknown alu_op, or alu_sel not matching the op's class: out_data=0, but addr/en/valid still pass through.
- Shifts: amount = src_data1[SH_W-1:0], value = src_data2. SRA replicates the MSB.
- Add/sub wrap modulo 2^DATA_W; no overflow trap.
- SLT/SLTU: out_data = {0…0, lt}.
- in_valid=0 or flush=1: registers load out_valid=0, out_en=0; out_data/addr hold.

Divider FSM: IDLE → BUSY → FINISH → IDLE
- IDLE: if in_valid, alu_sel=101, a divide op, and flush=0, then at the edge:
  - latch absolute operands (for DIV), result signs, dest addr/en;
  - cnt = DATA_W; go to BUSY.
- BUSY: one restoring-division quotient bit per edge; cnt decrements. When cnt reaches 0, go to FINISH.
- FINISH: apply sign correction combinationally.
  - Quotient sign = sign(a) XOR sign(b); remainder takes the dividend's sign.
  - At the edge: lo_out=quotient, hi_out=remainder, hi_lo_we=1 for exactly one cycle, out_valid=1, out_en=0; go to IDLE.
- Latency: accept edge E, result registered at edge E+DATA_W+1 (33 cycles at DATA_W=32).

stall_req and pipeline handshake
- stall_req = (IDLE & in_valid & divide & ~flush) | BUSY.
- stall_req is 0 in FINISH, so upstream advances on the same edge the result registers.
- Upstream holds inputs stable while stall_req=1. The divider ignores those held inputs in BUSY (no restart).
- While BUSY, out_valid=0.

Divide-by-zero
- Still takes the full latency.
- lo_out = all ones, hi_out = dividend (signed and unsigned alike).

Signed corner case
- DIV of most-negative value by −1: lo_out = most-negative value, hi_out = 0.

flush
- In BUSY or FINISH: return to IDLE next edge; hi_lo_we=0, out_valid=0, stall_req drops the same cycle.
- flush has priority over a new accept on the same edge.

Decomposition:
- Package ex_pkg holds:
  - ALU_SEL_* constants (3-bit) and ALU_OP_* constants (8-bit) listed above;
  - divider state enum {DIV_IDLE, DIV_BUSY, DIV_FINISH}.
- Sub-module ex_div (parametrised by DATA_W) owns the FSM, counter, partial remainder, and sign fix-up.
- Its interface is start/signed/a/b/abort → busy/done/quot/rem; the top derives stall_req from it.
- ex_stage_mc holds the combinational ALU and the output registers.

Test Plan:
- OR: src1=0x0000FF00, src2=0x00F000F0, wr_addr=5, wr_en=1 → next edge out_data=0x00F0FFF0, out_addr=5, out_en=1, out_valid=1.
- SRA: src1=4, src2=0x80000000 → out_data=0xF8000000. SLT with src1=0xFFFFFFFF, src2=1 → out_data=1; SLTU with the same operands → 0.
- DIVU 100/7:
  - stall_req=1 from the accept cycle through BUSY;
  - hi_lo_we pulses exactly once, 33 edges after accept, with lo_out=14, hi_out=2;
  - stall_req=0 in the FINISH cycle.
- DIV −7/2 → lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. DIV 0x80000000/−1 → lo_out=0x80000000, hi_out=0. DIVU 9/0 → lo_out=0xFFFFFFFF, hi_out=9.
- Abort mid-divide:
  - flush asserted 10 cycles into a DIV → FSM back to IDLE next edge, no hi_lo_we, stall_req=0;
  - a following OR completes normally.
  - Separately, reset low mid-divide → all outputs 0 immediately (asynchronously), no hi_lo_we after release.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants and types for the execute stage.
package ex_pkg;

  localparam logic [2:0] ALU_SEL_LOGIC = 3'b001;
  localparam logic [2:0] ALU_SEL_SHIFT = 3'b010;
  localparam logic [2:0] ALU_SEL_ARITH = 3'b100;
  localparam logic [2:0] ALU_SEL_DIV   = 3'b101;

  localparam logic [7:0] ALU_OP_OR   = 8'h25;
  localparam logic [7:0] ALU_OP_AND  = 8'h24;
  localparam logic [7:0] ALU_OP_XOR  = 8'h26;
  localparam logic [7:0] ALU_OP_NOR  = 8'h27;
  localparam logic [7:0] ALU_OP_SLL  = 8'h7C;
  localparam logic [7:0] ALU_OP_SRL  = 8'h02;
  localparam logic [7:0] ALU_OP_SRA  = 8'h03;
  localparam logic [7:0] ALU_OP_ADDU = 8'h21;
  localparam logic [7:0] ALU_OP_SUBU = 8'h23;
  localparam logic [7:0] ALU_OP_SLT  = 8'h2A;
  localparam logic [7:0] ALU_OP_SLTU = 8'h2B;
  localparam logic [7:0] ALU_OP_DIV  = 8'h1A;
  localparam logic [7:0] ALU_OP_DIVU = 8'h1B;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_FINISH} div_state_t;

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up applied combinationally in FINISH.
module ex_div
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sgn,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] q, r, dvs;
  logic              neg_q, neg_r, dz;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   trial, diff;
  logic              ge;

  assign a_neg = sgn & a[DATA_W-1];
  assign b_neg = sgn & b[DATA_W-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  // Shift next dividend bit into the partial remainder and try to subtract.
  assign trial = {r, q[DATA_W-1]};
  assign diff  = trial - {1'b0, dvs};
  assign ge    = trial >= {1'b0, dvs};

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_FINISH);
  // Divide-by-zero forces an all-ones quotient; the remainder path already
  // yields the dividend because nothing is ever subtracted.
  assign quot = dz ? '1 : (neg_q ? -q : q);
  assign rem  = neg_r ? -r : r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: abort wins everywhere; held inputs are ignored outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE:   if (start && !abort) state_nxt = DIV_BUSY;
      DIV_BUSY:   if (abort) state_nxt = DIV_IDLE;
                  else if (cnt == CNT_W'(1)) state_nxt = DIV_FINISH;
      DIV_FINISH: state_nxt = DIV_IDLE;
      default:    state_nxt = DIV_IDLE;
    endcase
  end

  // Operand latch on accept, then one restoring step per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (state == DIV_IDLE && start && !abort) begin
      cnt   <= CNT_W'(DATA_W);
      q     <= abs_a;
      r     <= '0;
      dvs   <= abs_b;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      dz    <= (b == '0);
    end else if (state == DIV_BUSY) begin
      cnt <= cnt - CNT_W'(1);
      q   <= {q[DATA_W-2:0], ge};
      r   <= ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Registered execute stage: single-cycle ALU plus iterative divider for HI/LO.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [2:0]        alu_sel,
  input  logic [7:0]        alu_op,
  input  logic [DATA_W-1:0] src_data1,
  input  logic [DATA_W-1:0] src_data2,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_en,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              hi_lo_we,
  output logic              stall_req
);

  localparam int SH_W = $clog2(DATA_W);

  logic              is_div, div_start, div_busy, div_done;
  logic [DATA_W-1:0] div_quot, div_rem, res;
  logic [ADDR_W-1:0] div_addr;
  logic [SH_W-1:0]   shamt;

  assign is_div    = (alu_sel == ALU_SEL_DIV) &&
                     (alu_op == ALU_OP_DIV || alu_op == ALU_OP_DIVU);
  assign div_start = in_valid & is_div & ~flush;
  assign shamt     = src_data1[SH_W-1:0];
  // Held inputs during FINISH are not a new request: only IDLE can accept.
  assign stall_req = reset & ~flush &
                     ((~div_busy & ~div_done & in_valid & is_div) | div_busy);

  ex_div #(.DATA_W(DATA_W)) u_div (
    .clk   (clk),
    .rst_n (reset),
    .start (div_start),
    .sgn   (alu_op == ALU_OP_DIV),
    .a     (src_data1),
    .b     (src_data2),
    .abort (flush),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot),
    .rem   (div_rem)
  );

  // Single-cycle result; an op outside its selected class yields zero.
  always_comb begin
    res = '0;
    case (alu_sel)
      ALU_SEL_LOGIC: case (alu_op)
        ALU_OP_OR:  res = src_data1 | src_data2;
        ALU_OP_AND: res = src_data1 & src_data2;
        ALU_OP_XOR: res = src_data1 ^ src_data2;
        ALU_OP_NOR: res = ~(src_data1 | src_data2);
        default:    res = '0;
      endcase
      ALU_SEL_SHIFT: case (alu_op)
        ALU_OP_SLL: res = src_data2 << shamt;
        ALU_OP_SRL: res = src_data2 >> shamt;
        ALU_OP_SRA: res = $unsigned($signed(src_data2) >>> shamt);
        default:    res = '0;
      endcase
      ALU_SEL_ARITH: case (alu_op)
        ALU_OP_ADDU: res = src_data1 + src_data2;
        ALU_OP_SUBU: res = src_data1 - src_data2;
        ALU_OP_SLT:  res = {{(DATA_W-1){1'b0}}, $signed(src_data1) < $signed(src_data2)};
        ALU_OP_SLTU: res = {{(DATA_W-1){1'b0}}, src_data1 < src_data2};
        default:     res = '0;
      endcase
      default: res = '0;
    endcase
  end

  // Destination of the divide in flight, reported with the HI/LO result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         div_addr <= '0;
    else if (div_start && !div_busy && !div_done) div_addr <= wr_addr;
  end

  // Output registers: flush > divide completion > single-cycle op > bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_en    <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      hi_lo_we  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_en    <= 1'b0;
      hi_lo_we  <= 1'b0;
    end else if (div_done) begin
      lo_out    <= div_quot;
      hi_out    <= div_rem;
      hi_lo_we  <= 1'b1;
      out_valid <= 1'b1;
      out_en    <= 1'b0;
      out_addr  <= div_addr;
    end else if (in_valid && !is_div) begin
      out_data  <= res;
      out_addr  <= wr_addr;
      out_en    <= wr_en;
      out_valid <= 1'b1;
      hi_lo_we  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_en    <= 1'b0;
      hi_lo_we  <= 1'b0;
    end
  end

endmodule
